// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arb_pkg
//  Purpose  : Shared types and default widths for the cache/memory arbiter.
//             arb_state_t - arbiter FSM states
//             grant_t     - which cache port owns the transaction
//  Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

  localparam int C_ADDR_W = 16;
  localparam int C_LINE_W = 128;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2,
    RESP   = 2'd3
  } arb_state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

endpackage
`default_nettype wire

// File: rtl/cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : cache_mem_arbiter
//  Purpose  : Round-robin arbiter placing the I-cache miss port and the D-cache
//             miss/writeback port onto a single physical-memory line port.
//             One transaction in flight; request fields are registered at
//             grant and read data is registered before being returned.
//  Ports    : clk, reset_n                 clock, async active-low reset
//             i_read/i_addr                I-cache line-fill request
//             i_rdata/i_resp               I-cache returned line / done pulse
//             d_read/d_write/d_addr/d_wdata D-cache fill or writeback request
//             d_rdata/d_resp               D-cache returned line / done pulse
//             pmem_read/pmem_write         memory strobes, held until pmem_resp
//             pmem_addr/pmem_wdata         registered memory address / line
//             pmem_rdata/pmem_resp         memory read line / completion
//  Revision : 1.0 - initial release
// ============================================================================
module cache_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = C_ADDR_W,
  parameter int LINE_W = C_LINE_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_addr,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  arb_state_t r_state;
  arb_state_t w_state_next;
  grant_t     r_last_grant;
  grant_t     r_winner;
  grant_t     w_pick;
  logic       r_op_write;
  logic       w_grant;
  logic       w_req_i;
  logic       w_req_d;
  logic       w_busy;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and round-robin pick
  // --------------------------------------------------------------------------
  always_comb begin
    w_req_i      = i_read;
    w_req_d      = d_read | d_write;
    w_grant      = 1'b0;
    w_pick       = GRANT_I;
    w_state_next = r_state;

    // D wins when it is alone, or on a tie when I had the previous grant.
    if (w_req_d && (!w_req_i || (r_last_grant == GRANT_I))) begin
      w_pick = GRANT_D;
    end

    case (r_state)
      IDLE: begin
        if (w_req_i || w_req_d) begin
          w_grant      = 1'b1;
          w_state_next = (w_pick == GRANT_D) ? D_BUSY : I_BUSY;
        end
      end
      I_BUSY, D_BUSY: begin
        if (pmem_resp) begin
          w_state_next = RESP;
        end
      end
      RESP:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output decode: strobes follow the (asynchronously reset) state, so they
  // fall the instant reset_n is asserted.
  // --------------------------------------------------------------------------
  always_comb begin
    w_busy     = (r_state == I_BUSY) || (r_state == D_BUSY);
    pmem_read  = w_busy & ~r_op_write;
    pmem_write = w_busy &  r_op_write;
    i_resp     = (r_state == RESP) && (r_winner == GRANT_I);
    d_resp     = (r_state == RESP) && (r_winner == GRANT_D);
  end

  // --------------------------------------------------------------------------
  // Transaction fields and returned-line registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last_grant <= GRANT_I;
      r_winner     <= GRANT_I;
      r_op_write   <= 1'b0;
      pmem_addr    <= '0;
      pmem_wdata   <= '0;
      i_rdata      <= '0;
      d_rdata      <= '0;
    end else begin
      if (w_grant) begin
        r_last_grant <= w_pick;
        r_winner     <= w_pick;
        if (w_pick == GRANT_D) begin
          // Read and write together is malformed; the write takes precedence.
          r_op_write <= d_write;
          pmem_addr  <= d_addr;
          pmem_wdata <= d_wdata;
        end else begin
          r_op_write <= 1'b0;
          pmem_addr  <= i_addr;
          pmem_wdata <= '0;
        end
      end

      if (w_busy && pmem_resp && !r_op_write) begin
        if (r_winner == GRANT_D) begin
          d_rdata <= pmem_rdata;
        end else begin
          i_rdata <= pmem_rdata;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cache_mem_arbiter
//  Purpose  : Directed self-checking bench for cache_mem_arbiter. Inputs are
//             driven and outputs sampled on the falling clock edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cache_mem_arbiter;

  localparam int ADDR_W = 16;
  localparam int LINE_W = 128;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              i_read;
  logic [ADDR_W-1:0] i_addr;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_addr;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  int checks = 0;
  int errors = 0;

  logic [LINE_W-1:0] exp_d_rdata;
  logic [LINE_W-1:0] exp_i_rdata;
  logic [LINE_W-1:0] data_k;

  localparam logic [LINE_W-1:0] DEAD_LINE = 128'h0123_4567_89AB_CDEF_0011_2233_4455_DEAD;
  localparam logic [LINE_W-1:0] WB_LINE   = 128'hA5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5;

  cache_mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_read     (i_read),
    .i_addr     (i_addr),
    .i_rdata    (i_rdata),
    .i_resp     (i_resp),
    .d_read     (d_read),
    .d_write    (d_write),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_rdata    (d_rdata),
    .d_resp     (d_resp),
    .pmem_read  (pmem_read),
    .pmem_write (pmem_write),
    .pmem_addr  (pmem_addr),
    .pmem_wdata (pmem_wdata),
    .pmem_rdata (pmem_rdata),
    .pmem_resp  (pmem_resp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [LINE_W-1:0] obs,
                       input logic [LINE_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n    = 1'b0;
    i_read     = 1'b0;
    i_addr     = '0;
    d_read     = 1'b0;
    d_write    = 1'b0;
    d_addr     = '0;
    d_wdata    = '0;
    pmem_rdata = '0;
    pmem_resp  = 1'b0;
    step();
    // Reset values
    check("rst_pmem_read",  {127'd0, pmem_read},  '0);
    check("rst_pmem_write", {127'd0, pmem_write}, '0);
    check("rst_pmem_addr",  {112'd0, pmem_addr},  '0);
    check("rst_i_rdata",    i_rdata, '0);
    check("rst_d_rdata",    d_rdata, '0);
    check("rst_resps",      {126'd0, i_resp, d_resp}, '0);
    step();
    reset_n = 1'b1;

    // ---- 1. I-cache alone ----
    i_read = 1'b1;
    i_addr = 16'h1230;
    step();
    check("t1_pmem_read", {127'd0, pmem_read}, 1);
    check("t1_pmem_addr", {112'd0, pmem_addr}, 128'h1230);
    check("t1_pmem_write", {127'd0, pmem_write}, 0);
    step();
    step();
    step();
    check("t1_still_read", {127'd0, pmem_read}, 1);
    check("t1_no_resp_yet", {127'd0, i_resp}, 0);
    pmem_resp  = 1'b1;
    pmem_rdata = DEAD_LINE;
    step();
    pmem_resp = 1'b0;
    check("t1_i_resp",    {127'd0, i_resp}, 1);
    check("t1_d_resp",    {127'd0, d_resp}, 0);
    check("t1_i_rdata",   i_rdata, DEAD_LINE);
    check("t1_read_low",  {127'd0, pmem_read}, 0);
    i_read = 1'b0;
    step();
    check("t1_resp_1cyc", {127'd0, i_resp}, 0);

    // ---- 2. Tie right after reset: D first ----
    do_reset();
    check("t2_rdata_clr", i_rdata, '0);
    i_read = 1'b1;
    i_addr = 16'h1230;
    d_read = 1'b1;
    d_addr = 16'h4000;
    step();
    check("t2_first_addr", {112'd0, pmem_addr}, 128'h4000);
    pmem_resp  = 1'b1;
    pmem_rdata = 128'hAAAA;
    step();
    pmem_resp = 1'b0;
    check("t2_d_resp",  {127'd0, d_resp}, 1);
    check("t2_i_resp0", {127'd0, i_resp}, 0);
    check("t2_d_rdata", d_rdata, 128'hAAAA);
    d_read = 1'b0;
    step();
    check("t2_idle_gap", {127'd0, pmem_read}, 0);
    step();
    check("t2_second_addr", {112'd0, pmem_addr}, 128'h1230);
    pmem_resp  = 1'b1;
    pmem_rdata = 128'hBBBB;
    step();
    pmem_resp = 1'b0;
    check("t2_i_resp",      {127'd0, i_resp}, 1);
    check("t2_i_rdata",     i_rdata, 128'hBBBB);
    check("t2_d_rdata_hold", d_rdata, 128'hAAAA);
    i_read = 1'b0;
    step();

    // ---- 3. Continuous tie: D,I,D,I ----
    exp_d_rdata = 128'hAAAA;
    i_read = 1'b1;
    d_read = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check("t3_addr", {112'd0, pmem_addr}, (k % 2 == 0) ? 128'h4000 : 128'h1230);
      data_k     = 128'h1000 + 128'(k);
      pmem_resp  = 1'b1;
      pmem_rdata = data_k;
      step();
      pmem_resp = 1'b0;
      check("t3_d_resp", {127'd0, d_resp}, (k % 2 == 0) ? 128'd1 : 128'd0);
      check("t3_i_resp", {127'd0, i_resp}, (k % 2 == 0) ? 128'd0 : 128'd1);
      if (k % 2 == 0) exp_d_rdata = data_k;
      step();
      check("t3_resp_width", {126'd0, i_resp, d_resp}, 0);
    end
    i_read = 1'b0;
    d_read = 1'b0;
    check("t3_d_rdata", d_rdata, exp_d_rdata);

    // ---- 4. Writeback, fields ignored after grant ----
    d_write = 1'b1;
    d_addr  = 16'h8010;
    d_wdata = WB_LINE;
    step();
    d_addr  = 16'h0000;
    d_wdata = '0;
    check("t4_pmem_write", {127'd0, pmem_write}, 1);
    check("t4_pmem_read",  {127'd0, pmem_read}, 0);
    check("t4_wdata",      pmem_wdata, WB_LINE);
    step();
    check("t4_addr_held",  {112'd0, pmem_addr}, 128'h8010);
    check("t4_wdata_held", pmem_wdata, WB_LINE);
    pmem_resp  = 1'b1;
    pmem_rdata = 128'hBAD;
    step();
    pmem_resp = 1'b0;
    check("t4_d_resp",       {127'd0, d_resp}, 1);
    check("t4_d_rdata_keep", d_rdata, exp_d_rdata);
    d_write = 1'b0;
    step();
    // Read and write together behaves as a write
    d_read  = 1'b1;
    d_write = 1'b1;
    d_addr  = 16'h8020;
    step();
    check("t4_rw_write", {127'd0, pmem_write}, 1);
    check("t4_rw_read",  {127'd0, pmem_read}, 0);
    pmem_resp = 1'b1;
    step();
    pmem_resp = 1'b0;
    check("t4_rw_resp",  {127'd0, d_resp}, 1);
    check("t4_rw_rdata", d_rdata, exp_d_rdata);
    d_read  = 1'b0;
    d_write = 1'b0;
    step();

    // ---- 5. Reset mid-transaction ----
    exp_i_rdata = i_rdata;
    i_read = 1'b1;
    i_addr = 16'h1230;
    step();
    check("t5_busy", {127'd0, pmem_read}, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("t5_read_drop", {127'd0, pmem_read}, 0);
    i_read    = 1'b0;
    pmem_resp = 1'b1;
    step();
    check("t5_rdata_clr", i_rdata, '0);
    pmem_resp = 1'b0;
    reset_n   = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check("t5_no_resp",  {126'd0, i_resp, d_resp}, 0);
      check("t5_idle",     {126'd0, pmem_read, pmem_write}, 0);
    end

    // ---- 6. Spurious and long pmem_resp ----
    pmem_resp  = 1'b1;
    pmem_rdata = 128'hFFFF;
    step();
    pmem_resp = 1'b0;
    check("t6_spur_resp", {126'd0, i_resp, d_resp}, 0);
    step();
    check("t6_spur_resp2", {126'd0, i_resp, d_resp}, 0);
    check("t6_spur_rdata", {i_rdata | d_rdata}, '0);
    d_read = 1'b1;
    d_addr = 16'h4000;
    step();
    check("t6_busy", {127'd0, pmem_read}, 1);
    pmem_resp  = 1'b1;
    pmem_rdata = 128'hC0C0;
    step();
    d_read = 1'b0;
    check("t6_d_resp", {127'd0, d_resp}, 1);
    check("t6_d_rdata", d_rdata, 128'hC0C0);
    step();
    check("t6_single1", {126'd0, i_resp, d_resp}, 0);
    step();
    pmem_resp = 1'b0;
    check("t6_single2", {126'd0, i_resp, d_resp}, 0);
    step();
    check("t6_idle", {126'd0, pmem_read, pmem_write}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
